// File: rtl/wb_trace_fifo_pkg.sv
// Shared definitions for the writeback trace capture FIFO.
//   trace_entry_t : one captured register write {pc, wen, wnum, wdata}, 73 bits
//   TRACE_ENTRY_WD / *_LSB : packed width and field offsets of an entry
package wb_trace_fifo_pkg;

  localparam int TRACE_ENTRY_WD = 73;
  localparam int WDATA_LSB      = 0;
  localparam int WNUM_LSB       = 32;
  localparam int WEN_LSB        = 37;
  localparam int PC_LSB         = 41;

  // Field order matches the offsets above (wdata in the low bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/wb_trace_fifo_sync_fifo_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : mem[i_raddr], combinational
// Storage is deliberately not reset.
module sync_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 73
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Capture FIFO behind the core's writeback debug port. Every qualifying register
// write is pushed as one entry; a show-ahead valid/ready port drains it. Entries
// that arrive while full are dropped but counted (sticky overflow + saturating
// drop counter, cleared by clr_ovf).
//   clk, rst                     : clock, synchronous active-high reset
//   trace_en                     : capture enable (draining is unaffected)
//   debug_wb_pc/rf_wen/wnum/wdata: writeback debug port
//   out_valid/out_ready          : read handshake; out_* shows the head entry
//   count                        : occupancy 0..DEPTH
//   overflow, drop_cnt, clr_ovf  : loss reporting and its clear
module wb_trace_fifo
  import wb_trace_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter bit FILTER_R0 = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic [31:0]      debug_wb_pc,
  input  logic [3:0]       debug_wb_rf_wen,
  input  logic [4:0]       debug_wb_rf_wnum,
  input  logic [31:0]      debug_wb_rf_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [3:0]       out_wen,
  output logic [4:0]       out_wnum,
  output logic [31:0]      out_wdata,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_ovf
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_drop_cnt;

  logic         w_cap, w_pop, w_push, w_drop, w_full;
  trace_entry_t w_wentry, w_rentry;

  assign w_full = (r_count == FULL);
  assign w_cap  = trace_en && (|debug_wb_rf_wen) &&
                  !(FILTER_R0 && (debug_wb_rf_wnum == 5'd0));
  assign w_pop  = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_drop = w_cap && w_full && !w_pop;

  assign w_wentry = '{pc: debug_wb_pc, wen: debug_wb_rf_wen,
                      wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};

  sync_fifo_ram #(.DEPTH(DEPTH), .AW(AW), .W(TRACE_ENTRY_WD)) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wentry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rentry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes effect before a same-cycle drop, so that drop is still recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clr_ovf) begin
      r_overflow <= w_drop;
      r_drop_cnt <= CNT_W'(w_drop);
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign out_valid = (r_count != '0);
  assign out_pc    = w_rentry.pc;
  assign out_wen   = w_rentry.wen;
  assign out_wnum  = w_rentry.wnum;
  assign out_wdata = w_rentry.wdata;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo (DEPTH=16, FILTER_R0=1).
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        rst, trace_en, out_ready, clr_ovf;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        out_valid, overflow;
  logic [31:0] out_pc, out_wdata;
  logic [3:0]  out_wen;
  logic [4:0]  out_wnum;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  wb_trace_fifo dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wen(out_wen), .out_wnum(out_wnum), .out_wdata(out_wdata),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one write for one cycle, then deassert wen.
  task automatic wr(input logic [31:0] pc, input logic [3:0] wen,
                    input logic [4:0] wnum, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_wen = wen;
    debug_wb_rf_wnum = wnum; debug_wb_rf_wdata = wd;
    tick();
    debug_wb_rf_wen = 4'h0;
  endtask

  function automatic logic [4:0] wn(input int i);
    return 5'(1 + (i % 31));
  endfunction

  function automatic logic [3:0] we(input int i);
    return 4'(4'h1 << (i % 4));
  endfunction

  initial begin
    rst = 1'b1; trace_en = 1'b1; out_ready = 1'b1; clr_ovf = 1'b0;
    debug_wb_pc = '0; debug_wb_rf_wen = '0; debug_wb_rf_wnum = '0; debug_wb_rf_wdata = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) begin
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_count", 64'(count), 64'd0);
      check("idle_ovf", 64'(overflow), 64'd0);
      check("idle_drop", 64'(drop_cnt), 64'd0);
      tick();
    end

    // 2: single write, visible next cycle, popped the cycle after
    out_ready = 1'b0;
    wr(32'hBFC00000, 4'hF, 5'd3, 32'h1234);
    check("one_valid", 64'(out_valid), 64'd1);
    check("one_pc", 64'(out_pc), 64'hBFC00000);
    check("one_wen", 64'(out_wen), 64'hF);
    check("one_wnum", 64'(out_wnum), 64'd3);
    check("one_wdata", 64'(out_wdata), 64'h1234);
    check("one_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    check("one_popped_count", 64'(count), 64'd0);
    check("one_popped_valid", 64'(out_valid), 64'd0);

    // 3: filtered / unqualified writes
    wr(32'h100, 4'hF, 5'd0, 32'h1);
    check("r0_filtered", 64'(count), 64'd0);
    wr(32'h104, 4'h0, 5'd5, 32'h2);
    check("wen0_ignored", 64'(count), 64'd0);
    trace_en = 1'b0;
    wr(32'h108, 4'hF, 5'd5, 32'h3);
    check("trace_off_ignored", 64'(count), 64'd0);
    trace_en = 1'b1;

    // 4: 18 captures with no consumer -> 16 held, 2 dropped
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) wr(32'h1000 + 32'(i), we(i), wn(i), 32'hA0000000 | 32'(i));
    check("fill_count", 64'(count), 64'd16);
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_drop", 64'(drop_cnt), 64'd2);
    trace_en = 1'b0;  // draining continues with capture off
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc", 64'(out_pc), 64'(32'h1000 + 32'(i)));
      check("drain_wen", 64'(out_wen), 64'(we(i)));
      check("drain_wnum", 64'(out_wnum), 64'(wn(i)));
      check("drain_wdata", 64'(out_wdata), 64'(32'hA0000000 | 32'(i)));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_ovf_sticky", 64'(overflow), 64'd1);
    trace_en = 1'b1;

    // 5: full, capture + pop in the same cycle
    for (int i = 0; i < 16; i++) wr(32'h2000 + 32'(i), 4'hF, wn(i), 32'(i));
    check("full2_count", 64'(count), 64'd16);
    out_ready = 1'b1;
    wr(32'h3000, 4'h3, 5'd7, 32'hCAFE);
    check("pushpop_count", 64'(count), 64'd16);
    check("pushpop_drop", 64'(drop_cnt), 64'd2);
    check("pushpop_head", 64'(out_pc), 64'h2001);
    for (int i = 1; i < 16; i++) begin
      check("pp_drain_pc", 64'(out_pc), 64'(32'h2000 + 32'(i)));
      tick();
    end
    check("pp_last_pc", 64'(out_pc), 64'h3000);
    check("pp_last_wdata", 64'(out_wdata), 64'hCAFE);
    check("pp_last_wen", 64'(out_wen), 64'h3);
    tick();
    out_ready = 1'b0;
    check("pp_empty", 64'(count), 64'd0);

    // 6: clear, then drop_cnt=5, then drop coinciding with clear
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 21; i++) wr(32'h4000 + 32'(i), 4'hF, wn(i), 32'(i));
    check("five_drop", 64'(drop_cnt), 64'd5);
    check("five_count", 64'(count), 64'd16);
    clr_ovf = 1'b1;
    wr(32'h5000, 4'hF, 5'd9, 32'h9);
    clr_ovf = 1'b0;
    check("clrdrop_ovf", 64'(overflow), 64'd1);
    check("clrdrop_drop", 64'(drop_cnt), 64'd1);
    check("clrdrop_count", 64'(count), 64'd16);
    check("clrdrop_head", 64'(out_pc), 64'h4000);

    // reset mid-fill discards everything; pointers restart
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h6000 + 32'(i), 4'hF, 5'd1, 32'(i));
    check("mid_count", 64'(count), 64'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    wr(32'h7000, 4'hC, 5'd31, 32'h77);
    check("post_rst_pc", 64'(out_pc), 64'h7000);
    check("post_rst_wnum", 64'(out_wnum), 64'd31);
    check("post_rst_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    check("ready_idle_valid", 64'(out_valid), 64'd1);
    tick();
    check("final_empty", 64'(count), 64'd0);
    tick();
    check("ready_while_empty", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
